cruise_speed_controller: RTL and testbench
==========================================

# cruise_speed_controller

Cruise-control state machine that sits directly downstream of the 8-bit magnitude comparator (ports `a`, `b`, `G`, `Eq`, `L`). It owns the target-speed register, which drives comparator input `b`, while the measured vehicle speed drives `a`. It consumes the comparator's `G`/`Eq`/`L` result, filters it for persistence, and issues registered throttle-up/throttle-down commands. It also handles driver on/off/set/resume/brake/accelerator/inc/dec controls.

## Interface
- `MIN_SPEED`, default 45: lowest speed at which cruise may engage, and the floor for `dec`.
- `MAX_SPEED`, default 200: highest target speed, and the ceiling for `inc`.
- `STEP`, default 1: amount `inc`/`dec` changes the target.
- `HOLD_CYCLES`, default 4: consecutive identical comparator cycles required before a throttle command; legal range is ≥1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `on`, `off`, `set`, `resume`, `inc`, `dec` in 1 each: driver buttons, single-cycle synchronous pulses.
- `brake`, `accel` in 1 each: pedal levels.
- `speed` in 8: measured speed, unsigned; also wired to comparator `a`.
- `G`, `Eq`, `L` in 1 each: comparator result for `a`=`speed` versus `b`=`cruise_speed`, exactly one-hot.
- `cruise_speed` out 8: target-speed register; drives comparator `b`.
- `throttle_up`, `throttle_down` out 1 each: never both high.
- `engaged` out 1: high only in CRUISE.
- `state` out 3: current state encoding, for debug.

## Operation
- **States:** OFF=0, STANDBY=1, CRUISE=2, OVERRIDE=3, SUSPEND=4. Codes 5–7 are illegal and return to OFF on the next edge.
- **Priority within a cycle:** `off` > `brake` > `accel` > `set` > `resume` > `inc`/`dec`. If `inc` and `dec` are asserted together, neither acts.
- **Any state + `off`:** go to OFF; `valid` cleared; `cruise_speed` held.
- **OFF:**
  - `on` → STANDBY.
  - All other inputs ignored.
- **STANDBY:**
  - `set` with MIN_SPEED ≤ `speed` ≤ MAX_SPEED → CRUISE; `cruise_speed`←`speed`; `valid`←1.
  - `resume` with `valid`=1 → CRUISE.
  - Out-of-range `set` is ignored.
- **CRUISE:**
  - `brake` → SUSPEND.
  - `accel` → OVERRIDE.
  - In-range `set` recaptures `speed`.
  - `inc`/`dec` move the target by STEP, saturating at MAX_SPEED/MIN_SPEED.
  - `speed` < MIN_SPEED → STANDBY (`valid` kept).
- **OVERRIDE:**
  - `brake` → SUSPEND.
  - `accel` low → CRUISE.
  - `inc`/`dec` ignored.
- **SUSPEND:**
  - `resume` with `brake` low and `speed` ≥ MIN_SPEED → CRUISE.
  - In-range `set` behaves as in STANDBY.
- **Persistence filter** (active only in CRUISE):
  - Counter tracks consecutive cycles with the same `{G,L}` value.
  - Counter clears on a result change, on any `cruise_speed` write, and whenever the next state is not CRUISE.
  - Count saturates at HOLD_CYCLES.
- **Throttle outputs:**
  - `throttle_up`=1 when the count reaches HOLD_CYCLES with `L` (speed below target).
  - `throttle_down`=1 when the count reaches HOLD_CYCLES with `G`.
  - `Eq` clears both on the next edge, without filtering.
  - Outside CRUISE, both are 0.
- **Width rules:**
  - `inc` saturation: `cruise_speed`+STEP is computed in 9 bits and clamped to MAX_SPEED, so there is no wrap at 255.
  - `dec` saturation: `cruise_speed`−STEP is clamped to MIN_SPEED, so there is no underflow.

## Timing
- **Reset values:** `state`=OFF, `cruise_speed`=0, `valid`=0, `throttle_up`=0, `throttle_down`=0, `engaged`=0, counter=0.
- **Reset mid-operation:** `rst_n` low forces the reset values immediately, asynchronously, from any state. Deassertion is sampled on the next `clk` rise.
- **Registered outputs:** all outputs are registered. A button pulse in cycle t changes `state`/`cruise_speed`/`engaged` visibly in cycle t+1.
- **Comparator timing:** the comparator is combinational on registered `cruise_speed`. `G`/`Eq`/`L` for a new target are valid in cycle t+1.
- **Filter latency:** a result held constant from cycle t through t+HOLD_CYCLES−1 asserts the throttle in cycle t+HOLD_CYCLES. Deassertion takes one cycle after `Eq` or after leaving CRUISE.

## Structure
- **Shared package `cruise_pkg`:** state encoding constants, default MIN_SPEED, MAX_SPEED, STEP and HOLD_CYCLES values, and a speed width of 8.
- **Sub-module `compare_hold_filter`:**
  - Parameter HOLD_CYCLES.
  - Inputs: `clk`, `rst_n`, `enable`, `clear`, `G`, `L`.
  - Outputs: `up`, `down`.
  - Counter width is `$clog2(HOLD_CYCLES+1)`.
- **Top module:** holds the FSM, target register, and saturation arithmetic.

## Test plan
- **Engage:** Reset, `on`, `speed`=60, `set` → CRUISE next cycle; `cruise_speed`=60, `engaged`=1, both throttles 0.
- **Filter, speed low:** Engaged at 60, `speed`=58 (comparator `L`) held 4 cycles → `throttle_up`=1 in cycle 5. `speed`=60 (`Eq`) → `throttle_up`=0 one cycle later.
- **Filter, glitch:** `L`,`L`,`G`,`G`,`G`,`G` → no `throttle_up` ever; `throttle_down`=1 after the 4th `G`.
- **Saturation:** Target 199, `inc` ×3 → `cruise_speed`=200. Target 46, `dec` ×3 → 45.
- **Brake/resume and priority:** `brake` in CRUISE → SUSPEND, throttles 0. `resume` with `speed`=50 → CRUISE, `cruise_speed` still 60. `set` and `brake` in the same cycle → SUSPEND, no capture.
- **Off and reset:** `off` then `on` → STANDBY. `resume` ignored because `valid`=0. Reset asserted mid-CRUISE → all outputs 0 immediately.

Source files
------------

// File: rtl/cruise_pkg.sv
// Shared definitions for the cruise-control block: speed width, default
// tuning values and the state encoding exposed on the debug port.
package cruise_pkg;

  localparam int SPEED_W         = 8;
  localparam int DEF_MIN_SPEED   = 45;
  localparam int DEF_MAX_SPEED   = 200;
  localparam int DEF_STEP        = 1;
  localparam int DEF_HOLD_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_STANDBY  = 3'd1,
    ST_CRUISE   = 3'd2,
    ST_OVERRIDE = 3'd3,
    ST_SUSPEND  = 3'd4
  } cruise_state_e;

endpackage

// File: rtl/cruise_speed_controller_filter.sv
// Persistence filter: a speed-too-low / speed-too-high result must hold for
// HOLD_CYCLES consecutive cycles before a registered throttle command issues.
module compare_hold_filter #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  input  logic G,
  input  logic L,
  output logic up,
  output logic down
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       res_q, res_d;
  logic             up_q, up_d;
  logic             down_q, down_d;

  always_comb begin
    res_d  = {G, L};
    cnt_d  = cnt_q;
    up_d   = 1'b0;
    down_d = 1'b0;
    if (!enable || clear) begin
      cnt_d = '0;
    end else if (cnt_q == '0 || res_q != {G, L}) begin
      // First cycle of a new result counts as one.
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    // An equal result (G=L=0) drops both commands without any filtering.
    up_d   = (cnt_d == CNT_MAX) && L && !G;
    down_d = (cnt_d == CNT_MAX) && G && !L;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      res_q  <= '0;
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      up_q   <= up_d;
      down_q <= down_d;
    end
  end

  assign up   = up_q;
  assign down = down_q;

endmodule

// File: rtl/cruise_speed_controller.sv
// Cruise-control FSM: owns the target-speed register feeding the external
// comparator and turns its filtered result into throttle commands.
module cruise_speed_controller
  import cruise_pkg::*;
#(
  parameter int MIN_SPEED   = DEF_MIN_SPEED,
  parameter int MAX_SPEED   = DEF_MAX_SPEED,
  parameter int STEP        = DEF_STEP,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               on,
  input  logic               off,
  input  logic               set,
  input  logic               resume,
  input  logic               inc,
  input  logic               dec,
  input  logic               brake,
  input  logic               accel,
  input  logic [SPEED_W-1:0] speed,
  input  logic               G,
  input  logic               Eq,
  input  logic               L,
  output logic [SPEED_W-1:0] cruise_speed,
  output logic               throttle_up,
  output logic               throttle_down,
  output logic               engaged,
  output logic [2:0]         state
);

  localparam int SPEED_XW = SPEED_W + 1;
  localparam logic [SPEED_W-1:0]  MIN_S  = SPEED_W'(MIN_SPEED);
  localparam logic [SPEED_W-1:0]  MAX_S  = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0]  STEP_S = SPEED_W'(STEP);
  localparam logic [SPEED_XW-1:0] MIN_X  = SPEED_XW'(MIN_SPEED);
  localparam logic [SPEED_XW-1:0] MAX_X  = SPEED_XW'(MAX_SPEED);
  localparam logic [SPEED_XW-1:0] STEP_X = SPEED_XW'(STEP);

  cruise_state_e      state_q, state_d;
  logic [SPEED_W-1:0] cs_q, cs_d;
  logic               valid_q, valid_d;
  logic               engaged_q, engaged_d;
  logic               cs_we;

  logic               set_ok;
  logic               below_min;
  logic [SPEED_XW-1:0] inc_sum;
  logic [SPEED_W-1:0] inc_val;
  logic [SPEED_W-1:0] dec_val;

  // Saturating target arithmetic, widened so the sum cannot wrap at 255.
  always_comb begin
    set_ok    = (speed >= MIN_S) && (speed <= MAX_S);
    below_min = (speed < MIN_S);
    inc_sum   = {1'b0, cs_q} + STEP_X;
    inc_val   = (inc_sum > MAX_X) ? MAX_S : inc_sum[SPEED_W-1:0];
    dec_val   = ({1'b0, cs_q} < (MIN_X + STEP_X)) ? MIN_S : (cs_q - STEP_S);
  end

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    valid_d = valid_q;
    cs_we   = 1'b0;
    if (off) begin
      state_d = ST_OFF;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (on) state_d = ST_STANDBY;
        end
        ST_STANDBY, ST_SUSPEND: begin
          // Pedals outrank the engage buttons, so neither engages while pressed.
          if (!brake && !accel) begin
            if (set && set_ok) begin
              state_d = ST_CRUISE;
              cs_d    = speed;
              cs_we   = 1'b1;
              valid_d = 1'b1;
            end else if (resume && valid_q &&
                         (state_q == ST_STANDBY || !below_min)) begin
              state_d = ST_CRUISE;
            end
          end
        end
        ST_CRUISE: begin
          if (brake) begin
            state_d = ST_SUSPEND;
          end else if (accel) begin
            state_d = ST_OVERRIDE;
          end else if (below_min) begin
            state_d = ST_STANDBY;
          end else if (set) begin
            if (set_ok) begin
              cs_d  = speed;
              cs_we = 1'b1;
            end
          end else if (!resume && (inc ^ dec)) begin
            cs_d  = inc ? inc_val : dec_val;
            cs_we = 1'b1;
          end
        end
        ST_OVERRIDE: begin
          if (brake)       state_d = ST_SUSPEND;
          else if (!accel) state_d = ST_CRUISE;
        end
        default: state_d = ST_OFF;
      endcase
    end
    engaged_d = (state_d == ST_CRUISE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      cs_q      <= '0;
      valid_q   <= 1'b0;
      engaged_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      valid_q   <= valid_d;
      engaged_q <= engaged_d;
    end
  end

  // The filter only runs while we stay in CRUISE; a target write restarts it.
  compare_hold_filter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .enable((state_q == ST_CRUISE) && (state_d == ST_CRUISE)),
    .clear (cs_we),
    .G     (G && !Eq),
    .L     (L && !Eq),
    .up    (throttle_up),
    .down  (throttle_down)
  );

  assign cruise_speed = cs_q;
  assign engaged      = engaged_q;
  assign state        = state_q;

endmodule

// File: tb/tb_cruise_speed_controller.sv
// Directed bench for cruise_speed_controller with a behavioural comparator
// closing the loop from cruise_speed back to G/Eq/L.
module tb_cruise_speed_controller;

  localparam logic [2:0] S_OFF      = 3'd0;
  localparam logic [2:0] S_STANDBY  = 3'd1;
  localparam logic [2:0] S_CRUISE   = 3'd2;
  localparam logic [2:0] S_OVERRIDE = 3'd3;
  localparam logic [2:0] S_SUSPEND  = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       on, off, set, resume, inc, dec, brake, accel;
  logic [7:0] speed;
  logic       G, Eq, L;
  logic [7:0] cruise_speed;
  logic       throttle_up, throttle_down, engaged;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign G  = (speed > cruise_speed);
  assign Eq = (speed == cruise_speed);
  assign L  = (speed < cruise_speed);

  cruise_speed_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .on           (on),
    .off          (off),
    .set          (set),
    .resume       (resume),
    .inc          (inc),
    .dec          (dec),
    .brake        (brake),
    .accel        (accel),
    .speed        (speed),
    .G            (G),
    .Eq           (Eq),
    .L            (L),
    .cruise_speed (cruise_speed),
    .throttle_up  (throttle_up),
    .throttle_down(throttle_down),
    .engaged      (engaged),
    .state        (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    on = 0; off = 0; set = 0; resume = 0; inc = 0; dec = 0; brake = 0; accel = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    speed = 8'd0;
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (state !== S_OFF) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, S_OFF); end
    checks++; if (cruise_speed !== 8'd0) begin errors++; $display("FAIL reset_cs: got %0d want 0", cruise_speed); end
    checks++; if ({engaged, throttle_up, throttle_down} !== 3'b000) begin errors++; $display("FAIL reset_outs: got %b want 000", {engaged, throttle_up, throttle_down}); end
    rst_n = 1'b1;
    tick();
    speed = 8'd60; set = 1; tick(); set = 0;
    checks++; if (state !== S_OFF || cruise_speed !== 8'd0) begin errors++; $display("FAIL off_ignores_set: state=%0d cs=%0d want 0/0", state, cruise_speed); end
  endtask

  task automatic test_engage();
    on = 1; tick(); on = 0;
    checks++; if (state !== S_STANDBY) begin errors++; $display("FAIL on_standby: got %0d want %0d", state, S_STANDBY); end
    speed = 8'd60; set = 1; tick(); set = 0;
    checks++; if (state !== S_CRUISE) begin errors++; $display("FAIL engage_state: got %0d want %0d", state, S_CRUISE); end
    checks++; if (cruise_speed !== 8'd60) begin errors++; $display("FAIL engage_cs: got %0d want 60", cruise_speed); end
    checks++; if ({engaged, throttle_up, throttle_down} !== 3'b100) begin errors++; $display("FAIL engage_outs: got %b want 100", {engaged, throttle_up, throttle_down}); end
  endtask

  task automatic test_filter_low();
    speed = 8'd58;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (throttle_up !== (i == 4)) begin errors++; $display("FAIL low_up_%0d: got %b want %b", i, throttle_up, (i == 4)); end
    end
    checks++; if (throttle_down !== 1'b0) begin errors++; $display("FAIL low_down: got %b want 0", throttle_down); end
    speed = 8'd60; tick();
    checks++; if (throttle_up !== 1'b0) begin errors++; $display("FAIL eq_clears_up: got %b want 0", throttle_up); end
  endtask

  task automatic test_filter_glitch();
    logic [7:0] pat [6];
    pat = '{8'd58, 8'd58, 8'd62, 8'd62, 8'd62, 8'd62};
    for (int i = 0; i < 6; i++) begin
      speed = pat[i];
      tick();
      checks++; if (throttle_up !== 1'b0) begin errors++; $display("FAIL glitch_up_%0d: got %b want 0", i, throttle_up); end
      checks++; if (throttle_down !== (i == 5)) begin errors++; $display("FAIL glitch_down_%0d: got %b want %b", i, throttle_down, (i == 5)); end
    end
    speed = 8'd60; tick();
    checks++; if (throttle_down !== 1'b0) begin errors++; $display("FAIL eq_clears_down: got %b want 0", throttle_down); end
  endtask

  task automatic test_saturation();
    speed = 8'd199; set = 1; tick(); set = 0;
    checks++; if (cruise_speed !== 8'd199) begin errors++; $display("FAIL recapture: got %0d want 199", cruise_speed); end
    for (int i = 0; i < 3; i++) begin
      inc = 1; tick(); inc = 0;
      checks++; if (cruise_speed !== 8'd200) begin errors++; $display("FAIL inc_sat_%0d: got %0d want 200", i, cruise_speed); end
    end
    speed = 8'd46; set = 1; tick(); set = 0;
    checks++; if (cruise_speed !== 8'd46) begin errors++; $display("FAIL recapture46: got %0d want 46", cruise_speed); end
    for (int i = 0; i < 3; i++) begin
      dec = 1; tick(); dec = 0;
      checks++; if (cruise_speed !== 8'd45) begin errors++; $display("FAIL dec_sat_%0d: got %0d want 45", i, cruise_speed); end
    end
  endtask

  task automatic test_override_and_drop();
    accel = 1; tick();
    checks++; if (state !== S_OVERRIDE || engaged !== 1'b0) begin errors++; $display("FAIL override: state=%0d eng=%b want 3/0", state, engaged); end
    inc = 1; tick(); inc = 0;
    checks++; if (cruise_speed !== 8'd45) begin errors++; $display("FAIL override_inc: got %0d want 45", cruise_speed); end
    accel = 0; tick();
    checks++; if (state !== S_CRUISE) begin errors++; $display("FAIL override_exit: got %0d want %0d", state, S_CRUISE); end
    speed = 8'd50; inc = 1; dec = 1; tick(); inc = 0; dec = 0;
    checks++; if (cruise_speed !== 8'd45) begin errors++; $display("FAIL inc_dec_both: got %0d want 45", cruise_speed); end
    speed = 8'd40; tick();
    checks++; if (state !== S_STANDBY || engaged !== 1'b0) begin errors++; $display("FAIL below_min: state=%0d eng=%b want 1/0", state, engaged); end
    speed = 8'd210; set = 1; tick(); set = 0;
    checks++; if (state !== S_STANDBY || cruise_speed !== 8'd45) begin errors++; $display("FAIL set_out_of_range: state=%0d cs=%0d want 1/45", state, cruise_speed); end
    speed = 8'd50; resume = 1; tick(); resume = 0;
    checks++; if (state !== S_CRUISE || cruise_speed !== 8'd45) begin errors++; $display("FAIL standby_resume: state=%0d cs=%0d want 2/45", state, cruise_speed); end
  endtask

  task automatic test_brake_resume();
    speed = 8'd60; set = 1; tick(); set = 0;
    speed = 8'd58;
    repeat (4) tick();
    checks++; if (throttle_up !== 1'b1) begin errors++; $display("FAIL pre_brake_up: got %b want 1", throttle_up); end
    brake = 1; tick(); brake = 0;
    checks++; if (state !== S_SUSPEND) begin errors++; $display("FAIL brake: got %0d want %0d", state, S_SUSPEND); end
    checks++; if ({throttle_up, throttle_down} !== 2'b00) begin errors++; $display("FAIL brake_throttles: got %b want 00", {throttle_up, throttle_down}); end
    speed = 8'd50; resume = 1; tick(); resume = 0;
    checks++; if (state !== S_CRUISE || cruise_speed !== 8'd60) begin errors++; $display("FAIL suspend_resume: state=%0d cs=%0d want 2/60", state, cruise_speed); end
    speed = 8'd70; set = 1; brake = 1; tick(); set = 0; brake = 0;
    checks++; if (state !== S_SUSPEND || cruise_speed !== 8'd60) begin errors++; $display("FAIL set_brake_prio: state=%0d cs=%0d want 4/60", state, cruise_speed); end
  endtask

  task automatic test_off_reset();
    off = 1; tick(); off = 0;
    checks++; if (state !== S_OFF || cruise_speed !== 8'd60) begin errors++; $display("FAIL off: state=%0d cs=%0d want 0/60", state, cruise_speed); end
    on = 1; tick(); on = 0;
    checks++; if (state !== S_STANDBY) begin errors++; $display("FAIL off_on: got %0d want %0d", state, S_STANDBY); end
    resume = 1; tick(); resume = 0;
    checks++; if (state !== S_STANDBY) begin errors++; $display("FAIL resume_invalid: got %0d want %0d", state, S_STANDBY); end
    speed = 8'd70; set = 1; tick(); set = 0;
    speed = 8'd60;
    repeat (4) tick();
    checks++; if ({engaged, throttle_up} !== 2'b11) begin errors++; $display("FAIL pre_reset: got %b want 11", {engaged, throttle_up}); end
    rst_n = 1'b0;
    #1;
    checks++; if (state !== S_OFF || cruise_speed !== 8'd0) begin errors++; $display("FAIL async_reset_state: state=%0d cs=%0d want 0/0", state, cruise_speed); end
    checks++; if ({engaged, throttle_up, throttle_down} !== 3'b000) begin errors++; $display("FAIL async_reset_outs: got %b want 000", {engaged, throttle_up, throttle_down}); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_engage();
    test_filter_low();
    test_filter_glitch();
    test_saturation();
    test_override_and_drop();
    test_brake_resume();
    test_off_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
